fifo_reader: RTL

- Read-side sequencer for the FIFO buffer.
- Waits for the write side to report a full frame of N+1 entries, then drains exactly N+1 words from the synchronous FIFO RAM.
- Issues one pop pulse per word, so the external pop counter advances in lockstep with the internal index.
- Presents each word to the downstream consumer with a valid/ack handshake, and pulses done when the frame is finished.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/global_pkg.sv | 6 +
 rtl/fifo_reader_if.sv | 29 ++
 rtl/fifo_reader.sv | 85 ++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// FIFO buffer geometry, index type and read-side sequencer states.
package fifo_pkg;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 4;

    typedef logic [AW-1:0] counter_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        PRESENT,
        DONE
    } rd_state_t;

endpackage : fifo_pkg

// File: rtl/global_pkg.sv
// Types shared between the write and read sides of the FIFO buffer.
package global_pkg;

    typedef logic [3:0] nibble_t;

endpackage : global_pkg

// File: rtl/fifo_reader_if.sv
// Read-side bundle: frame request from the write side, RAM read port and
// the valid/ack consumer handshake. master = fifo_reader, slave = its environment.
interface fifo_reader_if;
    import global_pkg::*;
    import fifo_pkg::*;

    logic          start;
    nibble_t       N;
    logic [DW-1:0] rd_data;
    logic          out_ack;
    logic          pop;
    counter_t      rd_addr;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          busy;
    logic          done;

    modport master (
        input  start, N, rd_data, out_ack,
        output pop, rd_addr, out_data, out_valid, out_last, busy, done
    );

    modport slave (
        output start, N, rd_data, out_ack,
        input  pop, rd_addr, out_data, out_valid, out_last, busy, done
    );

endinterface : fifo_reader_if

// File: rtl/fifo_reader.sv
// Read-side sequencer: drains one frame of n_q+1 words from the synchronous
// FIFO RAM, one pop per word, and hands each word over with valid/ack.
module fifo_reader
    import fifo_pkg::*;
(
    input logic           clk,
    input logic           rst,
    fifo_reader_if.master bus
);

    rd_state_t     state_q, state_d;
    counter_t      idx_q, idx_d;
    counter_t      n_q, n_d;
    logic [DW-1:0] out_data_q, out_data_d;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            n_q        <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            n_q        <= n_d;
            out_data_q <= out_data_d;
        end
    end

    // NOTE: every variable gets its hold value first so no branch leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        n_d        = n_q;
        out_data_d = out_data_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    n_d     = counter_t'(bus.N);
                    idx_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                // RAM output is valid now, one cycle after the pop in FETCH.
                out_data_d = bus.rd_data;
                state_d    = PRESENT;
            end
            PRESENT: begin
                if (bus.out_ack) begin
                    if (idx_q == n_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + counter_t'(1);
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // All outputs decode registered state only, so reset clears them at once.
    assign bus.pop       = (state_q == FETCH);
    assign bus.rd_addr   = idx_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = (state_q == PRESENT);
    assign bus.out_last  = (state_q == PRESENT) && (idx_q == n_q);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);

endmodule : fifo_reader
